// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a slow clock/strobe in sys_clk cycles,
// with equal-period lock detection and a sticky stopped-input timeout.
module clk_ratio_meter #(
    parameter int                CNT_W      = 16,
    parameter logic [CNT_W-1:0]  MAX_PERIOD = 16'd50000,
    parameter int                LOCK_CNT   = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MEAS = 1'b1;

    localparam logic [3:0]       LOCK_N = 4'(LOCK_CNT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic             s1, s2, s3;
    logic             rise, fall;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hlatch;
    logic [3:0]       match;
    logic [3:0]       match_nxt;
    logic             have_prev;
    logic             same;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
    assign same = have_prev && (cnt == period);

    always_comb begin
        match_nxt = match;
        if (match != LOCK_N)
            match_nxt = match + 4'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            hlatch     <= '0;
            match      <= '0;
            have_prev  <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            s1         <= clk_in;
            s2         <= s1;
            s3         <= s2;
            meas_valid <= 1'b0;

            // Saturation at MAX_PERIOD guarantees a timeout before any wrap
            if (rise)
                cnt <= ONE;
            else if (cnt != MAX_PERIOD)
                cnt <= cnt + ONE;

            if (fall)
                hlatch <= cnt;

            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= MEAS;
                        timeout   <= 1'b0;
                        have_prev <= 1'b0;
                        match     <= '0;
                        locked    <= 1'b0;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hlatch;
                        meas_valid <= 1'b1;
                        have_prev  <= 1'b1;
                        if (same) begin
                            match  <= match_nxt;
                            locked <= (match_nxt == LOCK_N);
                        end else begin
                            match  <= '0;
                            locked <= 1'b0;
                        end
                    end else if (cnt == MAX_PERIOD) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        match   <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Scoreboard bench for clk_ratio_meter: directed divider waveforms,
// expected measurements queued at stimulus time and checked by a monitor.
module tb_clk_ratio_meter;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        clk_in    = 1'b0;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        meas_valid;
    logic        locked;
    logic        timeout;

    always #5 sys_clk = ~sys_clk;

    clk_ratio_meter #(
        .CNT_W(16),
        .MAX_PERIOD(16'd20),
        .LOCK_CNT(4)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .clk_in(clk_in),
        .period(period),
        .high_time(high_time),
        .meas_valid(meas_valid),
        .locked(locked),
        .timeout(timeout)
    );

    typedef struct {
        int per;
        int hmin;
        int hmax;
        bit lk;
        int gap;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_mv  = -1;
    int   to_cyc   = -1;
    logic to_q     = 1'b0;
    int   half_h   = -1;

    bit pend  = 0;
    bit pmeas = 0;
    int pn, phmin, phmax;

    always @(posedge sys_clk) cyc++;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge sys_clk) begin
        if (meas_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_meas_valid actual=period %0d required=none",
                         period);
            end else begin
                e_mon = sb.pop_front();
                chk("period", int'(period), e_mon.per);
                checks++;
                if (int'(high_time) < e_mon.hmin || int'(high_time) > e_mon.hmax) begin
                    failures++;
                    $display("FAIL high_time actual=%0d required=%0d..%0d",
                             high_time, e_mon.hmin, e_mon.hmax);
                end
                if (e_mon.hmin != e_mon.hmax) begin
                    if (half_h < 0)
                        half_h = int'(high_time);
                    else
                        chk("half_high_const", int'(high_time), half_h);
                end
                chk("locked", int'(locked), int'(e_mon.lk));
                if (e_mon.gap > 0)
                    chk("mv_gap", cyc - last_mv, e_mon.gap);
            end
            last_mv = cyc;
        end
        if (timeout && !to_q)
            to_cyc = cyc;
        to_q = timeout;
    end

    // One divider period: high h cycles, low n-h cycles, edges at negedge
    task automatic pulse(int n, int h, bit lk);
        bit this_meas;
        this_meas = pend;
        if (pend)
            sb.push_back('{pn, phmin, phmax, lk, pmeas ? pn : 0});
        clk_in = 1'b1;
        repeat (h) @(negedge sys_clk);
        clk_in = 1'b0;
        repeat (n - h) @(negedge sys_clk);
        pmeas = this_meas;
        pend  = 1;
        pn    = n;
        phmin = h;
        phmax = h;
    endtask

    // Divide-by-7 using both sys_clk edges: 3.5 cycles high, 3.5 low
    task automatic half_pulse(bit lk);
        bit this_meas;
        this_meas = pend;
        if (pend)
            sb.push_back('{pn, phmin, phmax, lk, pmeas ? pn : 0});
        #2 clk_in = 1'b1;
        #35 clk_in = 1'b0;
        #33;
        pmeas = this_meas;
        pend  = 1;
        pn    = 7;
        phmin = 3;
        phmax = 4;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_high_time"}, int'(high_time), 0);
        chk({tag, "_meas_valid"}, int'(meas_valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    initial begin
        repeat (6) begin
            @(negedge sys_clk);
            clk_in = ~clk_in;
        end
        #1;
        chk_zero("rst");
        clk_in = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        for (int i = 0; i < 12; i++)
            pulse(7, 3, i >= 5);

        for (int j = 0; j < 10; j++)
            pulse(5, 2, (j == 0) || (j >= 5));

        clk_in = 1'b0;
        pend   = 0;
        pmeas  = 0;
        for (int t = 0; t < 40 && to_cyc < 0; t++)
            @(negedge sys_clk);
        if (to_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_wait actual=none required=timeout");
        end
        chk("timeout_delay", to_cyc - last_mv, 20);
        chk("to_timeout", int'(timeout), 1);
        chk("to_locked", int'(locked), 0);
        chk("to_period", int'(period), 5);
        chk("to_high_time", int'(high_time), 2);
        chk("to_queue_empty", sb.size(), 0);

        pulse(7, 3, 0);
        chk("timeout_cleared", int'(timeout), 0);
        for (int i = 1; i < 7; i++)
            pulse(7, 3, i >= 5);
        chk("relock", int'(locked), 1);

        sys_rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        pend  = 0;
        pmeas = 0;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 7; i++)
            pulse(7, 3, i >= 5);

        for (int k = 0; k < 22; k++)
            half_pulse(1);

        for (int t = 0; t < 50 && sb.size() != 0; t++)
            @(negedge sys_clk);
        chk("queue_drained", sb.size(), 0);
        chk("half_locked", int'(locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
